// File: rtl/pid_channel_scheduler.sv
// rtl/pid_channel_scheduler.sv - round-robin scheduler time-sharing one PID core among NUM_CH loops
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ch_en, req          per-channel enable and level request (effective = req & ch_en)
//   setpoint_flat       channel k setpoint in bits [8k+7:8k]
//   feedback_flat       channel k feedback in bits [8k+7:8k]
//   gnt                 one-hot grant pulse, coincident with core_start
//   busy                high whenever a transaction is in flight
//   core_start          one-cycle launch pulse to the PID core
//   core_ch             channel being serviced
//   core_setpoint/_feedback  operands captured at grant, stable until the core answers
//   core_done/_result   core completion pulse and its 8-bit result (looked at only while waiting)
//   result_valid        one-cycle pulse when a result is delivered
//   result_ch, result   channel and value of the last delivery (result_ch also set on timeout)
//   timeout_err         one-cycle pulse when the core fails to answer in TIMEOUT cycles
module pid_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*8-1:0]   setpoint_flat,
  input  logic [NUM_CH*8-1:0]   feedback_flat,
  output logic [NUM_CH-1:0]     gnt,
  output logic                  busy,
  output logic                  core_start,
  output logic [CH_W-1:0]       core_ch,
  output logic [7:0]            core_setpoint,
  output logic [7:0]            core_feedback,
  input  logic                  core_done,
  input  logic [7:0]            core_result,
  output logic                  result_valid,
  output logic [CH_W-1:0]       result_ch,
  output logic [7:0]            result,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_DELIVER = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   rr_ptr;
  logic [7:0]        timer;
  logic [NUM_CH-1:0] eff;
  logic              found;
  logic [CH_W-1:0]   winner;
  logic [CH_W:0]     scan_sum;
  logic [CH_W-1:0]   scan_idx;
  logic              timer_hit;

  assign eff       = req & ch_en;
  assign timer_hit = (timer == 8'(TIMEOUT - 1));

  // Round-robin pick: walk upward from rr_ptr, wrapping at NUM_CH, and take
  // the first effective request. The extra sum bit lets non-power-of-two
  // channel counts wrap correctly.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (scan_sum >= (CH_W+1)'(NUM_CH)) begin
        scan_sum = scan_sum - (CH_W+1)'(NUM_CH);
      end
      scan_idx = scan_sum[CH_W-1:0];
      if (!found && eff[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A done in the same cycle as the timeout limit wins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (found) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_DELIVER;
        end else if (timer_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_DELIVER: state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Pulse outputs decode only the state and registered channel, so there is
  // no combinational path from any input to any output.
  always_comb begin
    gnt          = '0;
    core_start   = 1'b0;
    result_valid = 1'b0;
    timeout_err  = 1'b0;
    busy         = (state != S_IDLE);
    if (state == S_LAUNCH) begin
      gnt        = NUM_CH'(1) << core_ch;
      core_start = 1'b1;
    end
    if (state == S_DELIVER) result_valid = 1'b1;
    if (state == S_ABORT)   timeout_err  = 1'b1;
  end

  // Datapath registers: operand capture at grant, watchdog timer, result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      timer         <= '0;
      core_ch       <= '0;
      core_setpoint <= '0;
      core_feedback <= '0;
      result        <= '0;
      result_ch     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            core_ch       <= winner;
            core_setpoint <= setpoint_flat[{winner, 3'b000} +: 8];
            core_feedback <= feedback_flat[{winner, 3'b000} +: 8];
            rr_ptr        <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
          end
        end
        S_LAUNCH: begin
          timer <= '0;
        end
        S_WAIT: begin
          if (core_done) begin
            result    <= core_result;
            result_ch <= core_ch;
          end else if (timer_hit) begin
            result_ch <= core_ch;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
- Time-shares one PID datapath core among NUM_CH control loops.
- Each loop raises a request carrying its 8-bit setpoint and feedback.
- The scheduler grants requests round-robin, launches the core with a start/done handshake, and returns the clamped 8-bit result tagged with its channel.
- A watchdog recovers from a core that never signals done.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- CH_W, 2, channel index width, equal to clog2(NUM_CH)
- TIMEOUT, 16, maximum cycles spent in WAIT before abort (2..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ch_en  in  NUM_CH  per-channel enable; disabled channels are never granted
- req  in  NUM_CH  level request; held by requester until its gnt bit pulses
- setpoint_flat  in  NUM_CH*8  channel k setpoint in bits [8k+7:8k]
- feedback_flat  in  NUM_CH*8  channel k feedback in bits [8k+7:8k]
- gnt  out  NUM_CH  one-hot, one-cycle grant pulse
- busy  out  1  high in any state other than IDLE
- core_start  out  1  one-cycle launch pulse to the PID core
- core_ch  out  CH_W  channel being serviced
- core_setpoint  out  8  captured setpoint, stable from LAUNCH through WAIT
- core_feedback  out  8  captured feedback, stable from LAUNCH through WAIT
- core_done  in  1  core completion pulse; sampled only in WAIT
- core_result  in  8  core output, valid while core_done is high
- result_valid  out  1  one-cycle pulse when a result is delivered
- result_ch  out  CH_W  channel of last delivered result or timeout
- result  out  8  last delivered result; holds until the next delivery
- timeout_err  out  1  one-cycle pulse when WAIT times out

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; rr_ptr=0; timer=0.
  - All outputs 0, including captured operands, result and result_ch.
  - Reset asserted mid-transaction abandons the transaction. No result_valid or timeout_err pulse follows.
- Effective requests: eff = req & ch_en.
- States: IDLE, LAUNCH, WAIT, DELIVER, ABORT. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - If eff != 0, select the first set bit of eff searching upward from index rr_ptr, wrapping modulo NUM_CH.
  - On that edge: capture that channel's setpoint and feedback into core_setpoint/core_feedback; set core_ch to the winner; set rr_ptr to (winner+1) mod NUM_CH; go to LAUNCH.
  - If eff == 0: stay in IDLE; rr_ptr is unchanged.
- LAUNCH (exactly 1 cycle):
  - gnt[core_ch]=1 and core_start=1 in this same cycle.
  - timer cleared to 0; go to WAIT.
- WAIT:
  - Each cycle: if core_done=1, register result<=core_result and result_ch<=core_ch, then go to DELIVER.
  - Else if timer == TIMEOUT-1, register result_ch<=core_ch and go to ABORT.
  - Else timer increments by 1.
  - If core_done arrives in the same cycle as the timeout limit, done wins: DELIVER is taken, not ABORT.
- DELIVER (1 cycle): result_valid=1; go to IDLE.
- ABORT (1 cycle): timeout_err=1; result is unchanged; go to IDLE.
- core_done outside WAIT is ignored.
- Requests arriving or changing while busy are not sampled. Only the IDLE-cycle snapshot matters.
- Dropping a granted channel's req or ch_en after the grant has no effect on the transaction in flight.
- Minimum turnaround per transaction is 4 cycles: IDLE, LAUNCH, WAIT with done in the first cycle, DELIVER. Back-to-back requests therefore see one grant every 4 cycles when the core answers immediately.
- Fairness: with all channels continuously requesting, the grant order is 0,1,2,3,0,... No channel waits more than NUM_CH-1 transactions.
- core_setpoint and core_feedback are unsigned 8-bit copies; no arithmetic on them. result is passed through unmodified; clamping is the core's responsibility.

Test Plan:
- Reset sequence: hold rst=1 for 3 cycles with req=4'b1111 → all outputs 0, busy=0, no gnt. Release → first gnt=4'b0001.
- Single request: req=4'b0100, setpoint ch2=100, feedback ch2=60; core model returns done=1 with result=80 two cycles after core_start → gnt=4'b0100 with core_start; core_setpoint=100, core_feedback=60, core_ch=2; result_valid pulse with result=80, result_ch=2 exactly 3 cycles after core_start.
- Round-robin with all channels: req=4'b1111 held, ch_en=4'b1111, immediate-done core → grant sequence 0,1,2,3,0,1 at 4-cycle spacing. Then ch_en=4'b1011 → channel 2 is skipped; order 3,0,1,3.
- Timeout: core never asserts done, TIMEOUT=16 → timeout_err pulses once, 17 cycles after core_start; result keeps its prior value; no result_valid; next grant is to the next channel in round-robin order.
- Done at the limit: done asserted in the 16th WAIT cycle (timer=15) with result=0xAA → result_valid=1 with result=0xAA; timeout_err stays 0.
- Mid-operation reset and stray done: rst pulsed during WAIT → state IDLE and rr_ptr=0, with no result_valid or timeout_err afterwards. Separately, core_done pulsed while in IDLE → ignored, result unchanged.
